// File: rtl/alarm_supervisor_pkg.sv
// Shared definitions for the multi-tank alarm supervisor: channel state encoding and fault rule.
package alarm_supervisor_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPending = 2'd1,
    StActive  = 2'd2,
    StAcked   = 2'd3
  } alarm_state_e;

  function automatic logic fault_cond(input logic conflict, input logic mid_level);
    return conflict | ~mid_level;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One tank channel: 2-flop input synchronisers, saturating debounce counter and alarm FSM.
module alarm_channel
  import alarm_supervisor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mid_water_level,
  input  logic conflicting_values,
  input  logic ack,
  output logic active,
  output logic acked
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

  logic conf_meta_q, conf_sync_q, mid_meta_q, mid_sync_q;
  logic sfault;

  alarm_state_e    state_q;
  logic [CntW-1:0] cnt_q;

  // Synchronisers reset to the no-fault values so nothing is raised out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_meta_q <= 1'b0;
      conf_sync_q <= 1'b0;
      mid_meta_q  <= 1'b1;
      mid_sync_q  <= 1'b1;
    end else begin
      conf_meta_q <= conflicting_values;
      conf_sync_q <= conf_meta_q;
      mid_meta_q  <= mid_water_level;
      mid_sync_q  <= mid_meta_q;
    end
  end

  assign sfault = fault_cond(conf_sync_q, mid_sync_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sfault) begin
            cnt_q   <= CntOne;
            state_q <= (DEBOUNCE_CYCLES == 1) ? StActive : StPending;
          end else begin
            cnt_q <= '0;
          end
        end
        StPending: begin
          if (!sfault) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StActive;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        // Latched: only an ack leaves ACTIVE, whatever the fault is doing.
        StActive: begin
          if (ack) begin
            if (sfault) begin
              state_q <= StAcked;
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
        end
        StAcked: begin
          if (!sfault) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign active = (state_q == StActive);
  assign acked  = (state_q == StAcked);

endmodule

// File: rtl/alarm_supervisor.sv
// Multi-tank alarm supervisor: per-channel debounced latched alarms, ack fan-out, LED drive.
// Optional LED blinking for unacknowledged alarms is enabled by defining ALARM_BLINK_EN.
module alarm_supervisor
  import alarm_supervisor_pkg::*;
#(
  parameter int unsigned CHANNELS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 8,
  parameter int unsigned BLINK_HALF_PERIOD = 25000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNELS-1:0]               mid_water_level,
  input  logic [CHANNELS-1:0]               conflicting_values,
  input  logic                              ack,
  output logic                              alarm_on,
  output logic [CHANNELS-1:0]               alarm_active,
  output logic [CHANNELS-1:0]               alarm_acked,
  output logic [$clog2(CHANNELS+1)-1:0]     active_count
);

  localparam int unsigned CountW = $clog2(CHANNELS + 1);

  logic any_active, any_acked;
  logic alarm_on_d, alarm_on_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    alarm_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk               (clk),
      .rst_n             (rst_n),
      .mid_water_level   (mid_water_level[gi]),
      .conflicting_values(conflicting_values[gi]),
      .ack               (ack),
      .active            (alarm_active[gi]),
      .acked             (alarm_acked[gi])
    );
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      active_count = active_count + CountW'(alarm_active[i]);
    end
  end

  assign any_active = |alarm_active;
  assign any_acked  = |alarm_acked;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);
  localparam logic [BlinkW-1:0] BlinkOne  = BlinkW'(1);

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;

  // Held at the lit phase while nothing is ACTIVE so every new alarm starts on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (!any_active) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkOne;
    end
  end

  assign alarm_on_d = any_active ? blink_phase_q : any_acked;
`else
  assign alarm_on_d = any_active | any_acked;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_on_q <= 1'b0;
    end else begin
      alarm_on_q <= alarm_on_d;
    end
  end

  assign alarm_on = alarm_on_q;

endmodule
